// File: rtl/decoder_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// decoder_rr_arbiter_if
// Bundles the request/release handshake and the grant outputs of the
// round-robin arbiter that drives the 2:4 decoder select pins.
//   req[3:0]   requester lines, req[i] = requester i
//   done       owner releases the grant (meaningful only while gnt_valid)
//   a, b       grant index MSB/LSB, wired to decoder a/b
//   gnt_valid  {a,b} names a live owner
//   expired    one-cycle pulse when the hold limit revokes a grant
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface decoder_rr_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic       a;
  logic       b;
  logic       gnt_valid;
  logic       expired;

  modport master (
    output req,
    output done,
    input  a,
    input  b,
    input  gnt_valid,
    input  expired
  );

  modport slave (
    input  req,
    input  done,
    output a,
    output b,
    output gnt_valid,
    output expired
  );
endinterface

// File: rtl/decoder_rr_arbiter.sv
// ---------------------------------------------------------------------------
// decoder_rr_arbiter
// Four-way round-robin arbiter whose registered 2-bit grant index drives the
// select inputs of a 2:4 one-hot decoder. The decoder outputs are only
// meaningful while gnt_valid=1 (after reset the decoder shows d0=1 with
// gnt_valid=0).
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   decoder_rr_arbiter_if.slave: req, done in; a, b, gnt_valid,
//         expired out (all outputs registered)
//
// Parameters:
//   HOLD_MAX  max consecutive gnt_valid cycles per owner (1..2^CNT_W-1)
//   CNT_W     hold counter width
//
// Optional feature macro: DECODER_ARB_HOLD_LIMIT_EN
//   defined   -> grant is revoked after HOLD_MAX cycles, expired pulses
//   undefined -> no hold limit, expired is always 0
// ---------------------------------------------------------------------------
module decoder_rr_arbiter #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input logic                 clk,
  input logic                 rst,
  decoder_rr_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_idx;
  logic [1:0]       w_idx_next;
  logic [1:0]       r_ptr;
  logic [1:0]       w_ptr_next;
  logic             r_gnt_valid;
  logic             w_gnt_valid_next;
  logic             r_expired;
  logic             w_expired_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  logic [3:0]       w_req_rot;
  logic [1:0]       w_offset;
  logic [1:0]       w_sel;
  logic             w_owner_req;
  logic             w_limit;
  logic             w_release;

  // Requests rotated so that bit 0 is the requester at ptr; a fixed
  // lowest-bit-first priority encoder then implements the circular scan.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      assign w_req_rot[gi] = bus.req[r_ptr + 2'(gi)];
    end
  endgenerate

  always_comb begin
    w_offset = 2'd0;
    if (w_req_rot[0])      w_offset = 2'd0;
    else if (w_req_rot[1]) w_offset = 2'd1;
    else if (w_req_rot[2]) w_offset = 2'd2;
    else if (w_req_rot[3]) w_offset = 2'd3;
  end

  assign w_sel       = r_ptr + w_offset;
  assign w_owner_req = bus.req[r_idx];

`ifdef DECODER_ARB_HOLD_LIMIT_EN
  // Counter starts at 0 in the first grant cycle, so reaching HOLD_MAX-1
  // means gnt_valid has been high for exactly HOLD_MAX cycles at this edge.
  assign w_limit = (r_cnt == CNT_W'(HOLD_MAX - 1));
`else
  logic w_unused_cfg;
  assign w_limit      = 1'b0;
  assign w_unused_cfg = (HOLD_MAX == 0);
`endif

  assign w_release = bus.done | ~w_owner_req | w_limit;

  always_comb begin
    w_state_next     = r_state;
    w_idx_next       = r_idx;
    w_ptr_next       = r_ptr;
    w_gnt_valid_next = r_gnt_valid;
    w_expired_next   = 1'b0;
    w_cnt_next       = r_cnt;

    case (r_state)
      IDLE: begin
        // done is ignored here; {a,b} keeps its last value when no request.
        if (|bus.req) begin
          w_idx_next       = w_sel;
          w_gnt_valid_next = 1'b1;
          w_cnt_next       = '0;
          w_state_next     = GRANT;
        end
      end
      GRANT: begin
        if (w_release) begin
          // Old index stays on {a,b}; gnt_valid drops for at least one cycle.
          w_gnt_valid_next = 1'b0;
          w_ptr_next       = r_idx + 2'd1;
          w_state_next     = IDLE;
          // Only flag a revocation the owner did not ask for.
          w_expired_next   = w_limit & ~bus.done & w_owner_req;
        end else if (r_cnt != {CNT_W{1'b1}}) begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= 2'd0;
      r_ptr       <= 2'd0;
      r_gnt_valid <= 1'b0;
      r_expired   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_ptr       <= w_ptr_next;
      r_gnt_valid <= w_gnt_valid_next;
      r_expired   <= w_expired_next;
      r_cnt       <= w_cnt_next;
    end
  end

  assign bus.a         = r_idx[1];
  assign bus.b         = r_idx[0];
  assign bus.gnt_valid = r_gnt_valid;
  assign bus.expired   = r_expired;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_decoder_rr_arbiter
// Directed stimulus pushes the expected grant sequence (owner index, number
// of gnt_valid=0 cycles before the grant, number of gnt_valid=1 cycles) into
// a queue; a monitor on the falling clock edge pops and compares each grant
// as the DUT presents it. Works with or without DECODER_ARB_HOLD_LIMIT_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_decoder_rr_arbiter;

  logic clk = 1'b0;
  logic rst;

  decoder_rr_arbiter_if bus ();

  decoder_rr_arbiter #(
    .HOLD_MAX (3),
    .CNT_W    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int gap;   // -1: don't care
    int hold;  // -1: don't care
  } exp_t;

  exp_t exp_q[$];
  exp_t cur_exp;
  bit   cur_active = 1'b0;

  int n_checks    = 0;
  int n_fail      = 0;
  int n_expired   = 0;
  int exp_expired = 0;

  logic prev_valid = 1'b0;
  int   prev_idx   = 0;
  int   low_cnt    = 0;
  int   high_cnt   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void expect_grant(input int idx, input int gap, input int hold);
    exp_t e;
    e.idx  = idx;
    e.gap  = gap;
    e.hold = hold;
    exp_q.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: sample outputs mid-cycle, away from the active edge.
  always @(negedge clk) begin
    int idx;
    idx = {30'd0, bus.a, bus.b};
    if (bus.gnt_valid && !prev_valid) begin
      $display("[%0t] grant idx=%0d after %0d idle cycles", $time, idx, low_cnt);
      if (exp_q.size() == 0) begin
        check("unexpected_grant", 1, 0);
        cur_active = 1'b0;
      end else begin
        cur_exp    = exp_q.pop_front();
        cur_active = 1'b1;
        check("grant_idx", idx, cur_exp.idx);
        if (cur_exp.gap >= 0) check("grant_gap", low_cnt, cur_exp.gap);
      end
      high_cnt = 1;
    end else if (bus.gnt_valid && prev_valid) begin
      check("grant_stable", idx, prev_idx);
      high_cnt++;
    end else if (!bus.gnt_valid && prev_valid) begin
      $display("[%0t] release idx=%0d after %0d grant cycles", $time, prev_idx, high_cnt);
      if (cur_active && cur_exp.hold >= 0) check("grant_hold", high_cnt, cur_exp.hold);
      cur_active = 1'b0;
      low_cnt    = 1;
    end else begin
      low_cnt++;
    end
    if (bus.expired === 1'b1) begin
      n_expired++;
      check("expired_first_low_cycle", int'(!bus.gnt_valid && prev_valid), 1);
    end
    prev_valid = bus.gnt_valid;
    prev_idx   = idx;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    tick();
    tick();
    check("reset_gnt_valid", int'(bus.gnt_valid), 0);
    check("reset_a", int'(bus.a), 0);
    check("reset_b", int'(bus.b), 0);
    check("reset_expired", int'(bus.expired), 0);
    rst = 1'b0;

    // Single request from requester 2.
    expect_grant(2, -1, 1);
    bus.req = 4'b0100; tick();
    bus.done = 1'b1; bus.req = 4'b0000; tick();
    bus.done = 1'b0; tick();

    // Reset pointer back to 0, then all four requesting: 0,1,2,3,0.
    rst = 1'b1; tick(); rst = 1'b0;
    expect_grant(0, -1, 1);
    expect_grant(1, 1, 1);
    expect_grant(2, 1, 1);
    expect_grant(3, 1, 1);
    expect_grant(0, 1, 1);
    bus.req = 4'b1111; tick();
    for (int i = 0; i < 4; i++) begin
      bus.done = 1'b1; tick();
      bus.done = 1'b0; tick();
    end
    bus.done = 1'b1; tick();       // release owner 0, ptr -> 1
    bus.done = 1'b0;

    // Owner 3 released with req=1001: pointer wraps to 0.
    expect_grant(3, 1, 1);
    expect_grant(0, 1, 1);
    bus.req = 4'b1000; tick();
    bus.req = 4'b1001; bus.done = 1'b1; tick();
    bus.done = 1'b0; tick();
    bus.req = 4'b0000; tick();     // release by request drop, ptr -> 1
    tick();

    // Non-owner request ignored while owner 1 holds for two cycles.
    expect_grant(1, -1, 2);
    expect_grant(0, 1, 1);
    bus.req = 4'b0010; tick();
    bus.req = 4'b0011; tick();
    bus.done = 1'b1; tick();       // ptr -> 2, next scan 2,3,0
    bus.done = 1'b0; tick();
    bus.req = 4'b0000; tick();     // ptr -> 1
    tick();

    // done asserted in IDLE has no effect on the grant.
    expect_grant(2, -1, 1);
    bus.done = 1'b1; bus.req = 4'b0100; tick();
    tick();                        // done now releases owner 2, ptr -> 3
    bus.done = 1'b0; bus.req = 4'b0000; tick();

    // Reset in the middle of owner 2's grant; next grant is 1 from ptr 0.
    expect_grant(2, -1, 2);
    expect_grant(1, 1, 1);
    bus.req = 4'b0100; tick();
    bus.req = 4'b0110; tick();
    rst = 1'b1; tick();
    check("midgrant_reset_gnt_valid", int'(bus.gnt_valid), 0);
    check("midgrant_reset_ab", int'({bus.a, bus.b}), 0);
    check("midgrant_reset_expired", int'(bus.expired), 0);
    rst = 1'b0; tick();
    bus.req = 4'b0000; tick();     // ptr -> 2
    tick();

    // Single requester held 40 cycles with done=0.
`ifdef DECODER_ARB_HOLD_LIMIT_EN
    for (int i = 0; i < 10; i++) expect_grant(0, (i == 0) ? -1 : 1, 3);
    exp_expired = 10;
`else
    expect_grant(0, -1, 40);
    exp_expired = 0;
`endif
    bus.req = 4'b0001;
    repeat (40) tick();
    bus.req = 4'b0000;
    tick(); tick(); tick();

    @(negedge clk); #1;
    check("pending_grants", exp_q.size(), 0);
    check("expired_pulses", n_expired, exp_expired);
    check("final_gnt_valid", int'(bus.gnt_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_rr_arbiter.md
# decoder_rr_arbiter

Round-robin arbiter that owns the select inputs of the 2:4 one-hot decoder stage. It arbitrates four request lines and drives the 2-bit grant index (`a` = MSB, `b` = LSB) straight into the decoder's select pins. The decoder's `d0`..`d3` then form the one-hot grant, qualified by `gnt_valid`. It supports a release handshake and an optional hold-time limit.

## Interface
- `HOLD_MAX`, default 15: maximum consecutive cycles one owner may hold the grant. Used only when `DECODER_ARB_HOLD_LIMIT_EN` is defined. Legal range is 1..2^CNT_W-1.
- `CNT_W`, default 4: width of the hold counter.

Ports:
- `clk`  input  1  sole clock; all logic is on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req`  input  4  request per requester; `req[i]` means requester i.
- `done`  input  1  current owner releases the grant; sampled only while `gnt_valid`=1.
- `a`  output  1  grant index MSB, to decoder `a`.
- `b`  output  1  grant index LSB, to decoder `b`.
- `gnt_valid`  output  1  `{a,b}` names a live owner.
- `expired`  output  1  one-cycle pulse when a grant is forcibly revoked by the hold limit.

## Operation
- FSM has two states, IDLE and GRANT.
- All outputs are registered.
- Reset values:
  - state = IDLE
  - `a`=0, `b`=0
  - `gnt_valid`=0, `expired`=0
  - priority pointer `ptr`=0
  - hold counter = 0
- Downstream must ignore the decoder outputs while `gnt_valid`=0. This includes after reset, where the decoder shows `d0`=1.
- IDLE:
  - If `req`=0, remain in IDLE; `{a,b}` holds its last value.
  - Otherwise select the first asserted `req[i]` scanning i = `ptr`, `ptr`+1, … mod 4.
  - Register `{a,b}`=i, set `gnt_valid`=1, clear the hold counter, go to GRANT.
- GRANT: a release condition is any of:
  - `done`=1
  - `req[owner]`=0
  - hold limit reached (macro only)
- On release:
  - `gnt_valid`=0 next cycle, go to IDLE.
  - `ptr` = (owner+1) mod 4, wrapping 3→0.
  - `{a,b}` holds the old owner's index.
- In GRANT with no release condition: `{a,b}` stays stable and the hold counter increments, saturating at 2^CNT_W-1.
- Requests from non-owners are ignored while in GRANT.
- `done` sampled while in IDLE has no effect.
- A requester that drops `req` and reasserts it gets no priority advantage; `ptr` has already moved past it.

## Timing
- Grant latency: `req` is sampled at edge N; `gnt_valid`/`{a,b}` update after edge N. The decoder output is valid in the cycle after edge N.
- Release: `done` is sampled at edge M; `gnt_valid`=0 after edge M.
- Mandatory one-cycle gap: the earliest next grant is after edge M+1. Two grants are never back to back.
- `done` and a new `req` in the same cycle: release takes priority. The new request is considered in the following IDLE cycle.
- `rst` wins over every other input at any edge, including mid-grant.
  - Outputs take their reset values after that edge.
  - A requester granted before the reset must re-arbitrate from `ptr`=0.

## Configuration
- `DECODER_ARB_HOLD_LIMIT_EN` defined:
  - When the hold counter reaches `HOLD_MAX`-1 in GRANT, release occurs at that edge, so `gnt_valid` is high for exactly `HOLD_MAX` cycles.
  - `expired`=1 in the first cycle with `gnt_valid`=0, and only if `done`=0 and `req[owner]`=1 at that edge.
  - `ptr` advances as for a normal release.
- `DECODER_ARB_HOLD_LIMIT_EN` not defined:
  - No hold limit; a grant lasts until `done` or `req[owner]` drops.
  - `expired` is tied to 0 and `HOLD_MAX` is unused.

## Test plan
- Reset then `req`=4'b0100 → after one edge `{a,b}`=2'b10, `gnt_valid`=1. Decoder shows `d2`=1.
- `req`=4'b1111 held, `done` pulsed each grant → grant order 0,1,2,3,0. Each grant is separated by exactly one `gnt_valid`=0 cycle.
- Owner 3 released with `req`=4'b1001 → next grant is 0, proving `ptr` wraps 3→0.
- `rst`=1 while owner 2 is mid-grant with `req`=4'b0110 → `gnt_valid`=0 and `{a,b}`=00. Next grant is 1, since `ptr` restarts at 0.
- With the macro and `HOLD_MAX`=3, `req`=4'b0001 held and `done`=0 → `gnt_valid` high for 3 cycles, then `expired` pulses once. Regrant to 0 follows after the one-cycle gap.
- Without the macro, the same stimulus held for 40 cycles → `gnt_valid` stays 1 and `expired` stays 0 throughout.
